memory_access_sequencer: RTL and testbench
==========================================

// Module: memory_access_sequencer
// PURPOSE
//  Sequences CPU data/instruction memory transfers requested by the control unit's MOV/R_W microstore lines.
//  Splits byte, halfword and word accesses into byte beats on a byte-wide RAM port.
//  Assembles and scatters big-endian data, and returns MOC to the control unit when the transfer is complete.
//  Sits between the datapath (MAR/MDR) and the RAM model; it is the only master of the RAM port.
// PARAMETERS
//  ADDR_W       8  RAM byte-address width
//  WAIT_STATES  0  extra cycles added to every byte beat (0..7)
// PORTS
//  Clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  MOV        in   1       memory operation valid (level; held until MOC seen)
//  R_W        in   1       1 = read, 0 = write
//  Size       in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  Address    in   ADDR_W  byte address from MAR
//  DataIn     in   32      write data from MDR (right-justified)
//  DataOut    out  32      read data to MDR (zero-extended)
//  MOC        out  1       memory operation complete
//  Err        out  1       illegal size flagged with this MOC
//  ram_addr   out  ADDR_W  RAM byte address
//  ram_wdata  out  8       RAM write byte
//  ram_we     out  1       RAM write strobe (one cycle per write beat)
//  ram_rdata  in   8       RAM read byte (combinational from ram_addr)
// BEHAVIOUR
//  - Reset: state IDLE; MOC=0, Err=0, ram_we=0, DataOut=0, ram_addr=0, ram_wdata=0.
//  - Reset mid-transfer aborts it. Bytes already written stay in RAM. No MOC is issued.
//  - FSM states: IDLE, ACCESS, DONE.
//    - IDLE: on edge with MOV=1, latch Address/Size/R_W/DataIn, set beat=0, then:
//      - legal Size -> ACCESS.
//      - Size=11 -> DONE with Err=1; no RAM access; DataOut unchanged.
//    - ACCESS: beat count N = 1/2/4 for byte/half/word. Each beat lasts 1+WAIT_STATES cycles.
//      - ram_addr = aligned base + beat.
//      - Alignment: halfword clears Address[0]; word clears Address[1:0].
//      - Write: ram_wdata is the beat's byte, big-endian (lowest address = most significant byte
//        of the N-byte value held in DataIn[8N-1:0]); ram_we=1 only in the last cycle of the beat.
//      - Read: on the last cycle of the beat, ram_rdata is shifted into an assembly register, MSB first.
//        DataOut takes the zero-extended result on the edge leaving the final beat.
//      - After beat N-1 -> DONE.
//    - DONE: MOC=1, Err held.
//      - MOV=0 sampled -> IDLE; MOC and Err clear on that edge.
//      - If MOV already dropped during ACCESS, MOC is high for exactly one cycle.
//  - Latency: MOC rises N*(1+WAIT_STATES) edges after the edge that sampled MOV=1 in IDLE.
//    With WAIT_STATES=0: byte 1, word 4.
//  - MOV, R_W and Size changes after latch are ignored until IDLE.
//  - A new request needs MOV low for at least one sampled edge (4-phase handshake).
//  - Address wrap: base+beat is computed modulo 2^ADDR_W.
//  - ram_we is never 1 outside ACCESS, and never during reads.
// STRUCTURE
//  - Shared package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL), state encodings,
//    R_W polarity constants.
//  - One sub-module mem_beat_counter: beat index plus wait-state counter.
//    Outputs beat, last_cycle_of_beat and last_beat.
//  - Everything else is inline.
// TESTING
//  1. Word write 0xDEADBEEF @0x10, WAIT=0:
//     -> ram_we pulses at 0x10..0x13 with DE,AD,BE,EF; MOC 4 edges after MOV sampled.
//  2. Word read @0x13 (misaligned) of the same data:
//     -> aligned to 0x10; DataOut=0xDEADBEEF; Err=0.
//  3. Byte read @0x11 -> DataOut=0x000000AD, MOC after 1 edge.
//     Halfword write 0x1234 @0x21 -> bytes 0x20=12, 0x21=34.
//  4. WAIT_STATES=2, halfword read:
//     -> MOC 6 edges after request; each ram_addr held 3 cycles.
//  5. Size=11 -> MOC=1, Err=1 next cycle; ram_we never asserted; DataOut unchanged.
//  6. reset asserted at beat 2 of a word write:
//     -> outputs reset next edge; only bytes 0-1 written; no MOC.
//     MOV held high through reset starts a fresh transfer.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access sequencer: transfer sizes, R_W polarity, FSM states.
package mem_pkg;

  // Size field encodings from the microstore
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // R_W polarity
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } mem_state_e;

  // Index of the final byte beat for a legal size (beats run 0..N-1)
  function automatic logic [1:0] last_beat_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SZ_HALF: idx = 2'd1;
      SZ_WORD: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Beat index and wait-state counter for byte-wide RAM transfers.
// Held at zero while inactive so every transfer starts at beat 0, cycle 0.
module mem_beat_counter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       active,
  input  logic [1:0] last_idx,
  output logic [1:0] beat,
  output logic       last_cycle_of_beat,
  output logic       last_beat
);

  localparam logic [2:0] WaitLast = 3'(WAIT_STATES);

  logic [1:0] beat_q, beat_d;
  logic [2:0] wait_q, wait_d;

  // Decode end of beat / end of transfer from the current counts
  always_comb begin
    last_cycle_of_beat = (wait_q == WaitLast);
    last_beat          = (beat_q == last_idx);
    beat               = beat_q;
  end

  // Next-state: advance the wait counter, roll into the next beat on its last cycle
  always_comb begin
    beat_d = beat_q;
    wait_d = wait_q;
    if (!active) begin
      beat_d = '0;
      wait_d = '0;
    end else if (last_cycle_of_beat) begin
      beat_d = beat_q + 2'd1;
      wait_d = '0;
    end else begin
      wait_d = wait_q + 3'd1;
    end
  end

  // Counter registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      beat_q <= '0;
      wait_q <= '0;
    end else begin
      beat_q <= beat_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Splits byte/halfword/word CPU transfers into big-endian byte beats on a byte-wide RAM port
// and returns MOC to the control unit when the transfer completes.
module memory_access_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        size_q, size_d;
  logic              rw_q, rw_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       dout_q, dout_d;

  logic [ADDR_W-1:0] align_mask;
  logic [1:0]        beat;
  logic              last_cycle_of_beat;
  logic              last_beat;
  logic [1:0]        byte_idx;
  logic [7:0]        wbyte;
  logic              in_access;

  mem_beat_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_beat_counter (
    .Clk                (Clk),
    .reset              (reset),
    .active             (in_access),
    .last_idx           (last_beat_idx(size_q)),
    .beat               (beat),
    .last_cycle_of_beat (last_cycle_of_beat),
    .last_beat          (last_beat)
  );

  // Alignment mask for the incoming request and big-endian byte select for write beats
  always_comb begin
    case (Size)
      SZ_HALF: align_mask = ADDR_W'(1);
      SZ_WORD: align_mask = ADDR_W'(3);
      default: align_mask = '0;
    endcase
    in_access = (state_q == StAccess);
    // Lowest address carries the most significant byte of the N-byte value
    byte_idx  = last_beat_idx(size_q) - beat;
    case (byte_idx)
      2'd0:    wbyte = data_q[7:0];
      2'd1:    wbyte = data_q[15:8];
      2'd2:    wbyte = data_q[23:16];
      default: wbyte = data_q[31:24];
    endcase
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    size_d  = size_q;
    rw_d    = rw_q;
    data_d  = data_q;
    err_d   = err_q;
    asm_d   = asm_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (MOV) begin
          size_d = Size;
          rw_d   = R_W;
          data_d = DataIn;
          base_d = Address & ~align_mask;
          asm_d  = '0;
          if (Size == SZ_ILL) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (last_cycle_of_beat) begin
          if (rw_q == RW_READ) begin
            asm_d = {asm_q[15:0], ram_rdata};
          end
          if (last_beat) begin
            state_d = StDone;
            if (rw_q == RW_READ) begin
              // asm_q was cleared at latch, so short reads come out zero-extended
              dout_d = {asm_q, ram_rdata};
            end
          end
        end
      end
      StDone: begin
        if (!MOV) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      size_q  <= SZ_BYTE;
      rw_q    <= RW_READ;
      data_q  <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      err_q   <= err_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
    end
  end

  // Outputs: RAM port is quiet outside ACCESS; a write beat coinciding with reset is suppressed
  always_comb begin
    DataOut   = dout_q;
    MOC       = (state_q == StDone);
    Err       = (state_q == StDone) && err_q;
    ram_addr  = in_access ? (base_q + ADDR_W'(beat)) : '0;
    ram_wdata = (in_access && rw_q == RW_WRITE) ? wbyte : 8'h00;
    ram_we    = in_access && (rw_q == RW_WRITE) && last_cycle_of_beat && !reset;
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench for memory_access_sequencer: one instance with no wait states,
// one with two wait states, each with its own byte-wide RAM model.
module tb_memory_access_sequencer;

  logic        Clk;
  logic        reset;
  logic        MOV0, MOV1;
  logic        R_W;
  logic [1:0]  Size;
  logic [7:0]  Address;
  logic [31:0] DataIn;

  logic [31:0] DataOut0, DataOut1;
  logic        MOC0, MOC1, Err0, Err1;
  logic [7:0]  ram_addr0, ram_addr1, ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;
  logic        ram_we0, ram_we1;

  logic [7:0]  mem0 [0:255];
  logic [7:0]  mem1 [0:255];
  logic [15:0] wlog0 [$];
  int          we1_cnt;

  int n_checks;
  int n_pass;

  memory_access_sequencer #(
    .ADDR_W      (8),
    .WAIT_STATES (0)
  ) u_dut0 (
    .Clk       (Clk),
    .reset     (reset),
    .MOV       (MOV0),
    .R_W       (R_W),
    .Size      (Size),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut0),
    .MOC       (MOC0),
    .Err       (Err0),
    .ram_addr  (ram_addr0),
    .ram_wdata (ram_wdata0),
    .ram_we    (ram_we0),
    .ram_rdata (ram_rdata0)
  );

  memory_access_sequencer #(
    .ADDR_W      (8),
    .WAIT_STATES (2)
  ) u_dut1 (
    .Clk       (Clk),
    .reset     (reset),
    .MOV       (MOV1),
    .R_W       (R_W),
    .Size      (Size),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut1),
    .MOC       (MOC1),
    .Err       (Err1),
    .ram_addr  (ram_addr1),
    .ram_wdata (ram_wdata1),
    .ram_we    (ram_we1),
    .ram_rdata (ram_rdata1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign ram_rdata0 = mem0[ram_addr0];
  assign ram_rdata1 = mem1[ram_addr1];

  always @(posedge Clk) begin
    if (ram_we0) begin
      mem0[ram_addr0] <= ram_wdata0;
      wlog0.push_back({ram_addr0, ram_wdata0});
    end
    if (ram_we1) begin
      mem1[ram_addr1] <= ram_wdata1;
      we1_cnt <= we1_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Full 4-phase transfer on the zero-wait instance; lat counts edges from the sampling edge to MOC
  task automatic xfer0(input logic rw, input logic [1:0] sz, input logic [7:0] addr,
                       input logic [31:0] wd, output int lat, output logic err_seen);
    @(negedge Clk);
    R_W = rw; Size = sz; Address = addr; DataIn = wd; MOV0 = 1'b1;
    @(posedge Clk);
    lat = 0;
    err_seen = 1'b0;
    while (lat < 64) begin
      @(posedge Clk); #1;
      lat++;
      if (MOC0) begin
        err_seen = Err0;
        break;
      end
    end
    @(negedge Clk);
    MOV0 = 1'b0;
    @(posedge Clk); #1;
  endtask

  logic [7:0] addr_trace [6];
  int         lat;
  logic       err_seen;
  int         n;

  initial begin
    n_checks = 0; n_pass = 0; we1_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    reset = 1'b1; MOV0 = 1'b0; MOV1 = 1'b0;
    R_W = 1'b0; Size = 2'b00; Address = 8'h00; DataIn = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_moc", {31'b0, MOC0}, 32'd0);
    check("rst_err", {31'b0, Err0}, 32'd0);
    check("rst_we", {31'b0, ram_we0}, 32'd0);
    check("rst_dout", DataOut0, 32'h0);
    check("rst_addr", {24'b0, ram_addr0}, 32'h0);
    check("rst_wdata", {24'b0, ram_wdata0}, 32'h0);
    @(negedge Clk);
    reset = 1'b0;

    // 1. word write, big-endian beats 0x10..0x13
    wlog0.delete();
    xfer0(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, lat, err_seen);
    check("w_lat", lat, 32'd4);
    check("w_err", {31'b0, err_seen}, 32'd0);
    check("w_nbeats", wlog0.size(), 32'd4);
    if (wlog0.size() == 4) begin
      check("w_beat0", {16'b0, wlog0[0]}, 32'h10DE);
      check("w_beat1", {16'b0, wlog0[1]}, 32'h11AD);
      check("w_beat2", {16'b0, wlog0[2]}, 32'h12BE);
      check("w_beat3", {16'b0, wlog0[3]}, 32'h13EF);
    end
    check("w_moc_clr", {31'b0, MOC0}, 32'd0);

    // 2. misaligned word read aligns down to 0x10
    wlog0.delete();
    xfer0(1'b1, 2'b10, 8'h13, 32'h0, lat, err_seen);
    check("rw_lat", lat, 32'd4);
    check("rw_data", DataOut0, 32'hDEADBEEF);
    check("rw_err", {31'b0, err_seen}, 32'd0);
    check("rw_nowe", wlog0.size(), 32'd0);

    // 3. byte read, then halfword write with junk above the low 16 bits
    xfer0(1'b1, 2'b00, 8'h11, 32'h0, lat, err_seen);
    check("rb_lat", lat, 32'd1);
    check("rb_data", DataOut0, 32'h000000AD);
    xfer0(1'b0, 2'b01, 8'h21, 32'hFFFF1234, lat, err_seen);
    check("wh_lat", lat, 32'd2);
    check("wh_b20", {24'b0, mem0[8'h20]}, 32'h12);
    check("wh_b21", {24'b0, mem0[8'h21]}, 32'h34);
    check("wh_dout", DataOut0, 32'h000000AD);

    // 4. halfword read with two wait states: each address held 3 cycles, MOC after 6 edges
    mem1[8'h30] = 8'hA5;
    mem1[8'h31] = 8'h5A;
    @(negedge Clk);
    R_W = 1'b1; Size = 2'b01; Address = 8'h31; MOV1 = 1'b1;
    @(posedge Clk);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      addr_trace[i] = ram_addr1;
      if (MOC1) n++;
      @(posedge Clk);
    end
    #1;
    check("ws_early_moc", n, 32'd0);
    check("ws_moc", {31'b0, MOC1}, 32'd1);
    check("ws_data", DataOut1, 32'h0000A55A);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ws_addr%0d", i), {24'b0, addr_trace[i]}, (i < 3) ? 32'h30 : 32'h31);
    end
    check("ws_nowe", we1_cnt, 32'd0);
    @(negedge Clk);
    MOV1 = 1'b0;
    @(posedge Clk); #1;
    check("ws_moc_clr", {31'b0, MOC1}, 32'd0);

    // 5. illegal size: Err with MOC one edge later, no RAM traffic, DataOut kept
    wlog0.delete();
    xfer0(1'b0, 2'b11, 8'h50, 32'h55555555, lat, err_seen);
    check("ill_lat", lat, 32'd1);
    check("ill_err", {31'b0, err_seen}, 32'd1);
    check("ill_nowe", wlog0.size(), 32'd0);
    check("ill_dout", DataOut0, 32'h000000AD);
    check("ill_err_clr", {31'b0, Err0}, 32'd0);

    // MOV dropped during ACCESS: MOC lasts exactly one cycle
    @(negedge Clk);
    R_W = 1'b1; Size = 2'b10; Address = 8'h10; MOV0 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    MOV0 = 1'b0;
    n = 0;
    while (n < 64 && !MOC0) begin
      @(posedge Clk); #1;
      n++;
    end
    check("drop_moc", {31'b0, MOC0}, 32'd1);
    @(posedge Clk); #1;
    check("drop_moc_1cyc", {31'b0, MOC0}, 32'd0);

    // 6. reset during beat 2 of a word write; MOV held through reset restarts the transfer
    @(negedge Clk);
    R_W = 1'b0; Size = 2'b10; Address = 8'h40; DataIn = 32'h11223344; MOV0 = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    @(posedge Clk); #1;
    check("ra_moc", {31'b0, MOC0}, 32'd0);
    check("ra_dout", DataOut0, 32'h0);
    check("ra_addr", {24'b0, ram_addr0}, 32'h0);
    check("ra_b40", {24'b0, mem0[8'h40]}, 32'h11);
    check("ra_b41", {24'b0, mem0[8'h41]}, 32'h22);
    check("ra_b42", {24'b0, mem0[8'h42]}, 32'h00);
    check("ra_b43", {24'b0, mem0[8'h43]}, 32'h00);
    @(negedge Clk);
    reset = 1'b0;
    @(posedge Clk);
    lat = 0;
    while (lat < 64) begin
      @(posedge Clk); #1;
      lat++;
      if (MOC0) break;
    end
    check("rs_lat", lat, 32'd4);
    check("rs_b42", {24'b0, mem0[8'h42]}, 32'h33);
    check("rs_b43", {24'b0, mem0[8'h43]}, 32'h44);
    @(negedge Clk);
    MOV0 = 1'b0;
    repeat (2) @(posedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
